dp_aux_sink_responder: RTL
==========================

DP_AUX_SINK_RESPONDER -- requirements
Module: dp_aux_sink_responder

Interface
REQ-001 SHALL have parameter REPLY_GAP, default 4: idle cycles between request end and first reply byte (legal 1..15).
REQ-002 SHALL have parameter DPCD_DEPTH, default 16: number of DPCD bytes stored, at addresses 0x00000..DPCD_DEPTH-1.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port aux_req_vld, input, 1: high for each valid request byte (source AUX_START_STOP framing); request ends on first low cycle.
REQ-006 SHALL have port aux_req_byte, input, 8: request byte, sampled when aux_req_vld=1.
REQ-007 SHALL have port defer_en, input, 1: when 1 at request end, reply is DEFER.
REQ-008 SHALL have port aux_rep_vld, output, 1: high for each reply byte (drives PHY_START_STOP).
REQ-009 SHALL have port aux_rep_byte, output, 8: reply byte, valid when aux_rep_vld=1 (drives AUX_IN_OUT).
REQ-010 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have port proto_err, output, 1: one-cycle pulse on malformed or overlapping request.

Function
REQ-012 Request format SHALL be: byte0={cmd[3:0],addr[19:16]}, byte1=addr[15:8], byte2=addr[7:0], byte3=len-1; for writes, len data bytes follow.
REQ-013 cmd 4'b1000 SHALL be native write, 4'b1001 native read; any other cmd SHALL be answered NACK.
REQ-014 Reply byte0 SHALL be {status[3:0],4'b0000}: ACK=0000, NACK=0001, DEFER=0010.
REQ-015 FSM states SHALL be IDLE, HDR, WDATA, GAP, REPLY, DRAIN.
REQ-016 IDLE->HDR on aux_req_vld=1; HDR counts 4 bytes; after byte3, write ->WDATA, read/other -> awaits aux_req_vld=0 then GAP.
REQ-017 Range check SHALL be addr+len-1 <= DPCD_DEPTH-1 using 21-bit arithmetic (no wrap); failure gives NACK and no storage change.
REQ-018 WDATA SHALL store bytes at addr, addr+1, ... only if range-check and cmd pass and defer_en=0 at request end; storage commits only after full request seen.
REQ-019 GAP SHALL hold aux_rep_vld=0 for exactly REPLY_GAP cycles, counted from first cycle aux_req_vld=0.
REQ-020 REPLY SHALL drive aux_rep_vld=1 on contiguous cycles: 1 status byte, plus len data bytes for ACKed read; then IDLE.
REQ-021 Priority at request end SHALL be: malformed > DEFER > NACK > ACK.
REQ-022 Request ending with fewer than 4 header bytes, or write with fewer than len data bytes, SHALL be discarded: no reply, proto_err pulse, ->IDLE.
REQ-023 Write with more than len data bytes SHALL go to DRAIN, NACK, no storage change.
REQ-024 aux_req_vld=1 during GAP or REPLY SHALL be ignored except proto_err pulse; reply continues unaffected.
REQ-025 aux_rep_byte SHALL be 8'h00 whenever aux_rep_vld=0.

Reset
REQ-026 rst=1 SHALL force IDLE, aux_rep_vld=0, aux_rep_byte=8'h00, busy=0, proto_err=0, all counters 0 immediately.
REQ-027 DPCD storage SHALL reset to 0x00 except byte 0x00000=8'h14 (DPCD_REV 1.4), 0x00001=8'h1E (MAX_LINK_RATE 8.1G), 0x00002=8'h84 (4 lanes, enhanced frame).
REQ-028 rst mid-request or mid-reply SHALL abort with no partial write and no further reply bytes.

Structure
REQ-029 Shared package dp_aux_pkg SHALL hold cmd codes, reply status codes, FSM state enum and DPCD reset-value constants.
REQ-030 DPCD byte array SHALL be a sub-module dp_dpcd_regfile (1 write port, 1 read port, synchronous write, combinational read).

Verification
REQ-031 Read 0x00000 len 3 (bytes 90 00 00 02) -> after 4 idle cycles, reply 00 14 1E 84 on 4 consecutive cycles.
REQ-032 Write 0x00005 len 2 data AA 55 (80 00 05 01 AA 55), then read same -> replies 00, then 00 AA 55.
REQ-033 Read 0x0000F len 2 (90 00 0F 01) -> reply single byte 10; storage unchanged.
REQ-034 Any request with defer_en=1 -> single byte 20; write data not stored.
REQ-035 Request of only 2 bytes (90 00) -> no aux_rep_vld, one proto_err pulse, busy low next cycle.
REQ-036 rst asserted on 2nd reply data byte of a read -> aux_rep_vld=0 same cycle, IDLE, DPCD reset values restored.

Source files
------------

// File: rtl/dp_aux_pkg.sv
// Shared DP AUX definitions: command/status codes, responder FSM states, request header, DPCD reset image.
// Latency/backpressure: none (declarations only).
package dp_aux_pkg;

    localparam logic [3:0] CMD_NATIVE_WR = 4'b1000;
    localparam logic [3:0] CMD_NATIVE_RD = 4'b1001;

    localparam logic [3:0] STS_ACK   = 4'b0000;
    localparam logic [3:0] STS_NACK  = 4'b0001;
    localparam logic [3:0] STS_DEFER = 4'b0010;

    localparam logic [7:0] DPCD_REV_RST      = 8'h14;
    localparam logic [7:0] MAX_LINK_RATE_RST = 8'h1E;
    localparam logic [7:0] MAX_LANE_CNT_RST  = 8'h84;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_GAP,
        ST_REPLY,
        ST_DRAIN
    } aux_state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [19:0] addr;
        logic [7:0]  len_m1;
    } aux_hdr_t;

    function automatic logic [7:0] dpcd_rst_val(input int idx);
        case (idx)
            0:       return DPCD_REV_RST;
            1:       return MAX_LINK_RATE_RST;
            2:       return MAX_LANE_CNT_RST;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/dp_aux_sink_responder_if.sv
// AUX request/reply byte streams between a source-side framer (master) and the sink responder (slave).
// Latency/backpressure: none; plain valid-qualified byte streams.
interface dp_aux_sink_responder_if;
    logic       aux_req_vld;
    logic [7:0] aux_req_byte;
    logic       defer_en;
    logic       aux_rep_vld;
    logic [7:0] aux_rep_byte;
    logic       busy;
    logic       proto_err;

    modport master (
        output aux_req_vld, aux_req_byte, defer_en,
        input  aux_rep_vld, aux_rep_byte, busy, proto_err
    );

    modport slave (
        input  aux_req_vld, aux_req_byte, defer_en,
        output aux_rep_vld, aux_rep_byte, busy, proto_err
    );
endinterface

// File: rtl/dp_dpcd_regfile.sv
// DPCD byte store: one synchronous write port, one combinational read port, capability bytes preset on reset.
// Latency: write visible next cycle, read same cycle; no backpressure.
module dp_dpcd_regfile
    import dp_aux_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= dpcd_rst_val(i);
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : 8'h00;
endmodule

// File: rtl/dp_aux_sink_responder.sv
// DP AUX sink: parses native read/write requests, answers ACK/NACK/DEFER after REPLY_GAP idle cycles.
// Backpressure: none; bytes arriving while a reply is pending are dropped and flagged on proto_err.
module dp_aux_sink_responder
    import dp_aux_pkg::*;
#(
    parameter int REPLY_GAP  = 4,
    parameter int DPCD_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    dp_aux_sink_responder_if.slave aux
);
    localparam int AW = (DPCD_DEPTH > 1) ? $clog2(DPCD_DEPTH) : 1;

    aux_state_t    state_q, state_d;
    aux_hdr_t      hdr_q;
    logic [2:0]    hdr_cnt_q;
    logic [8:0]    data_cnt_q;
    logic [3:0]    gap_cnt_q;
    logic [3:0]    sts_q, end_sts;
    logic [8:0]    rep_cnt_q, rep_n_q, len_q;
    logic          rep_done_q, rep_last;
    logic [AW-1:0] rd_ptr_q;
    logic          commit_act_q, commit_busy;
    logic [8:0]    commit_cnt_q;
    logic          proto_err_q;
    logic          req_end, malformed, overlap;
    logic          cmd_ok, range_ok;
    logic [7:0]    rd_dat;
    logic [7:0]    data_buf [DPCD_DEPTH];

    assign len_q    = {1'b0, hdr_q.len_m1} + 9'd1;
    assign cmd_ok   = (hdr_q.cmd == CMD_NATIVE_WR) || (hdr_q.cmd == CMD_NATIVE_RD);
    assign range_ok = ({1'b0, hdr_q.addr} + {13'd0, hdr_q.len_m1}) <= 21'(DPCD_DEPTH - 1);
    assign rep_last = (rep_cnt_q == rep_n_q);
    // Write data lands in the DPCD only after the whole request is seen; the last commit beat is commit_cnt == len-1.
    assign commit_busy = commit_act_q && (commit_cnt_q != {1'b0, hdr_q.len_m1});

    always_comb begin
        if (aux.defer_en)                                  end_sts = STS_DEFER;
        else if (!cmd_ok || !range_ok || state_q == ST_DRAIN) end_sts = STS_NACK;
        else                                               end_sts = STS_ACK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_end   = 1'b0;
        malformed = 1'b0;
        overlap   = 1'b0;
        case (state_q)
            ST_IDLE: if (aux.aux_req_vld) state_d = ST_HDR;
            ST_HDR: begin
                if (aux.aux_req_vld) begin
                    if (hdr_cnt_q == 3'd3 && hdr_q.cmd == CMD_NATIVE_WR) state_d = ST_WDATA;
                end else if (hdr_cnt_q == 3'd4) begin
                    req_end = 1'b1;
                end else begin
                    malformed = 1'b1;
                end
            end
            ST_WDATA: begin
                if (aux.aux_req_vld) begin
                    if (data_cnt_q == len_q) state_d = ST_DRAIN;
                end else if (data_cnt_q == len_q) begin
                    req_end = 1'b1;
                end else begin
                    malformed = 1'b1;
                end
            end
            ST_DRAIN: if (!aux.aux_req_vld) req_end = 1'b1;
            ST_GAP: begin
                overlap = aux.aux_req_vld;
                if (gap_cnt_q == 4'd1) state_d = ST_REPLY;
            end
            ST_REPLY: begin
                overlap = aux.aux_req_vld;
                if ((rep_done_q || rep_last) && !commit_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // The first idle request cycle already counts as one gap cycle.
        if (req_end)   state_d = (REPLY_GAP > 1) ? ST_GAP : ST_REPLY;
        if (malformed) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q        <= '0;
            hdr_cnt_q    <= '0;
            data_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            sts_q        <= '0;
            rep_cnt_q    <= '0;
            rep_n_q      <= '0;
            rep_done_q   <= 1'b0;
            rd_ptr_q     <= '0;
            commit_act_q <= 1'b0;
            commit_cnt_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            proto_err_q <= malformed || overlap;
            if (state_q == ST_IDLE && aux.aux_req_vld) begin
                hdr_q.cmd  <= aux.aux_req_byte[7:4];
                hdr_q.addr <= {aux.aux_req_byte[3:0], 16'h0000};
                hdr_cnt_q  <= 3'd1;
                data_cnt_q <= '0;
            end
            if (state_q == ST_HDR && aux.aux_req_vld && hdr_cnt_q != 3'd4) begin
                case (hdr_cnt_q)
                    3'd1:    hdr_q.addr[15:8] <= aux.aux_req_byte;
                    3'd2:    hdr_q.addr[7:0]  <= aux.aux_req_byte;
                    default: hdr_q.len_m1     <= aux.aux_req_byte;
                endcase
                hdr_cnt_q <= hdr_cnt_q + 3'd1;
            end
            if (state_q == ST_WDATA && aux.aux_req_vld) data_cnt_q <= data_cnt_q + 9'd1;
            if (state_q == ST_GAP) gap_cnt_q <= gap_cnt_q - 4'd1;
            if (state_q == ST_REPLY && !rep_done_q) begin
                if (rep_last) rep_done_q <= 1'b1;
                else          rep_cnt_q  <= rep_cnt_q + 9'd1;
                if (rep_cnt_q != 9'd0) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (commit_act_q) begin
                commit_cnt_q <= commit_cnt_q + 9'd1;
                if (!commit_busy) commit_act_q <= 1'b0;
            end
            if (req_end) begin
                sts_q      <= end_sts;
                rep_cnt_q  <= '0;
                rep_done_q <= 1'b0;
                rd_ptr_q   <= hdr_q.addr[AW-1:0];
                gap_cnt_q  <= 4'(REPLY_GAP - 1);
                rep_n_q    <= (end_sts == STS_ACK && hdr_q.cmd == CMD_NATIVE_RD) ? len_q : 9'd0;
                if (end_sts == STS_ACK && hdr_q.cmd == CMD_NATIVE_WR) begin
                    commit_act_q <= 1'b1;
                    commit_cnt_q <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_WDATA && aux.aux_req_vld && 32'(data_cnt_q) < DPCD_DEPTH)
            data_buf[data_cnt_q[AW-1:0]] <= aux.aux_req_byte;
    end

    dp_dpcd_regfile #(
        .DEPTH (DPCD_DEPTH),
        .AW    (AW)
    ) u_dpcd (
        .clk   (clk),
        .rst   (rst),
        .we    (commit_act_q),
        .waddr (hdr_q.addr[AW-1:0] + commit_cnt_q[AW-1:0]),
        .wdata (data_buf[commit_cnt_q[AW-1:0]]),
        .raddr (rd_ptr_q),
        .rdata (rd_dat)
    );

    always_comb begin
        aux.busy         = (state_q != ST_IDLE);
        aux.aux_rep_vld  = (state_q == ST_REPLY) && !rep_done_q;
        aux.aux_rep_byte = 8'h00;
        if (state_q == ST_REPLY && !rep_done_q)
            aux.aux_rep_byte = (rep_cnt_q == 9'd0) ? {sts_q, 4'b0000} : rd_dat;
    end

    assign aux.proto_err = proto_err_q;
endmodule
